// File: rtl/display_scan_pkg.sv
// display_pkg: FSM states, segment codes and digit helpers shared by the display_scan files.
//   Contents: state_t, N_DIGITS, BCD_W, SEG_DIGIT/SEG_DASH/SEG_BLANK (active-high),
//             seg_decode() for one BCD digit, add3() for one double-dabble adjust step.
package display_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    localparam int N_DIGITS = 4;
    localparam int BCD_W = 4 * N_DIGITS;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        return d > 4'd9 ? SEG_DASH : SEG_DIGIT[d];
    endfunction

    // Each nibble is adjusted on its own; no carry ripples between digits.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < N_DIGITS; i++)
            r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: load handshake carrying the binary value into display_scan.
//   value : binary value to display (master -> slave)
//   load  : one-cycle latch request (master -> slave)
//   busy  : conversion in progress, load ignored (slave -> master)
interface display_scan_if #(parameter int WIDTH = 14);
    logic [WIDTH-1:0] value;
    logic             load;
    logic             busy;
    modport master(output value, output load, input busy);
    modport slave(input value, input load, output busy);
endinterface

// File: rtl/display_scan_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per cycle.
//   clk, reset : system clock, synchronous active-high reset
//   i_value    : binary value, latched when i_load is seen in IDLE
//   i_load     : start request
//   o_busy     : high from the cycle after the accepted load through COMMIT
//   o_done     : one-cycle pulse while in COMMIT, o_bcd is final then
//   o_bcd      : four BCD nibbles, digit 0 in bits 3:0
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_load,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_load) begin
                    r_shift <= i_value;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= CONVERT;
                end
                CONVERT: begin
                    // Top bits of the BCD word drop out only for values that show dashes anyway.
                    {r_bcd, r_shift} <= {add3(r_bcd), r_shift} << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= COMMIT;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/display_scan.sv
// display_scan: latches a product, converts it to BCD and scans it onto four 7-segment digits.
//   clk, reset    : system clock, synchronous active-high reset
//   i_clk_display : refresh level in the clk domain, each rising edge is one scan step
//   bus           : value/load/busy handshake (slave side)
//   o_anodes      : one-hot digit select, bit 0 rightmost
//   o_segments    : {g,f,e,d,c,b,a}
//   Both outputs are inverted when ACTIVE_LOW=1.
module display_scan
    import display_pkg::*;
#(
    parameter int WIDTH      = 14,
    parameter int MAX_VALUE  = 9999,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clk_display,
    display_scan_if.slave       bus,
    output logic [N_DIGITS-1:0] o_anodes,
    output logic [6:0]          o_segments
);
    localparam logic [WIDTH-1:0]    MAX_W   = WIDTH'(MAX_VALUE);
    localparam logic [N_DIGITS-1:0] AN_POL  = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]          SEG_POL = {7{ACTIVE_LOW}};
    localparam int                  IW      = $clog2(N_DIGITS);

    logic                w_busy;
    logic                w_done;
    logic [BCD_W-1:0]    w_bcd;
    logic [N_DIGITS-1:0] w_nz;
    logic [N_DIGITS-1:0] w_blank;
    logic [6:0]          w_seg;
    logic                w_step;

    logic                r_ovf;
    logic [BCD_W-1:0]    r_digits;
    logic [N_DIGITS-1:0] r_blank;
    logic                r_dash;
    logic                r_clk_display_q;
    logic [IW-1:0]       r_idx;
    logic [N_DIGITS-1:0] r_anodes;
    logic [6:0]          r_segments;

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
        .clk    (clk),
        .reset  (reset),
        .i_value(bus.value),
        .i_load (bus.load),
        .o_busy (w_busy),
        .o_done (w_done),
        .o_bcd  (w_bcd)
    );

    for (genvar d = 0; d < N_DIGITS; d++) assign w_nz[d] = |w_bcd[4*d +: 4];

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        w_blank = '0;
        for (int i = 1; i < N_DIGITS; i++) w_blank[i] = (w_nz >> i) == '0;
    end

    assign w_step = i_clk_display & ~r_clk_display_q;
    assign w_seg  = r_blank[r_idx] ? SEG_BLANK : r_dash ? SEG_DASH : seg_decode(r_digits[4*r_idx +: 4]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf           <= 1'b0;
            r_digits        <= '0;
            r_blank         <= '1;
            r_dash          <= 1'b0;
            r_clk_display_q <= 1'b0;
            r_idx           <= '0;
            r_anodes        <= AN_POL;
            r_segments      <= SEG_POL;
        end else begin
            r_clk_display_q <= i_clk_display;
            if (bus.load && !w_busy) r_ovf <= bus.value > MAX_W;
            if (w_done) begin
                r_digits <= w_bcd;
                r_blank  <= r_ovf ? '0 : w_blank;
                r_dash   <= r_ovf;
            end
            // A step reads the display register before any same-cycle commit lands.
            if (w_step) begin
                r_anodes   <= ({{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx) ^ AN_POL;
                r_segments <= w_seg ^ SEG_POL;
                r_idx      <= r_idx + 1'b1;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign o_anodes   = r_anodes;
    assign o_segments = r_segments;
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench; stimulus pushes expected scan outputs, a monitor pops them on each step.
module tb_display_scan;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    localparam logic [3:0] AN_SEL [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cd = 1'b0;
    logic [3:0] anodes;
    logic [6:0] segments;
    exp_t       exp_q[$];
    exp_t       last_exp = '{an: 4'hF, seg: 7'h7F};
    int         n_vec = 0;
    int         n_bad = 0;
    string      tname = "reset";

    display_scan_if #(.WIDTH(14)) bus();

    display_scan #(.WIDTH(14), .MAX_VALUE(9999), .ACTIVE_LOW(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_clk_display(cd),
        .bus          (bus),
        .o_anodes     (anodes),
        .o_segments   (segments)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int i, input logic [6:0] s);
        exp_t e;
        e.an  = AN_SEL[i];
        e.seg = s;
        exp_q.push_back(e);
    endtask

    task automatic step_now();
        cd = 1'b1;
        repeat (2) @(negedge clk);
        cd = 1'b0;
        repeat (3) @(negedge clk);
        check({"hold_", tname}, int'({anodes, segments}), int'(last_exp));
    endtask

    task automatic step();
        @(negedge clk);
        step_now();
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        push(0, s0);
        push(1, s1);
        push(2, s2);
        push(3, s3);
        repeat (4) step();
    endtask

    task automatic load(input logic [13:0] v, input int extra_at, input logic [13:0] extra_v);
        int cnt;
        cnt = 0;
        @(negedge clk);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (cnt == extra_at) begin
                bus.value = extra_v;
                bus.load  = 1'b1;
            end
            @(negedge clk);
            bus.load = 1'b0;
        end
        check({"busy_len_", tname}, cnt, 15);
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) prev = 1'b0;
            else begin
                if (cd && !prev) begin
                    #1;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL scan_unexpected_%s: step with no expectation, an=%h seg=%h", tname, anodes, segments);
                    end else begin
                        e = exp_q.pop_front();
                        last_exp = e;
                        check({"scan_", tname}, int'({anodes, segments}), int'(e));
                    end
                end
                prev = cd;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin
        bus.value = '0;
        bus.load  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_anodes", int'(anodes), 'hF);
        check("reset_segments", int'(segments), 'h7F);
        check("reset_busy", int'(bus.busy), 0);
        reset = 1'b0;
        frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);

        tname = "v1234";  load(14'd1234, 0, '0);  frame(7'h19, 7'h30, 7'h24, 7'h79);
        tname = "v7";     load(14'd7, 0, '0);     frame(7'h78, 7'h7F, 7'h7F, 7'h7F);
        tname = "v0";     load(14'd0, 0, '0);     frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
        tname = "v10000"; load(14'd10000, 0, '0); frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        tname = "v9999";  load(14'd9999, 0, '0);  frame(7'h10, 7'h10, 7'h10, 7'h10);
        tname = "v16383"; load(14'd16383, 0, '0); frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        tname = "v9801_ignore55"; load(14'd9801, 3, 14'd55); frame(7'h79, 7'h40, 7'h00, 7'h10);

        tname = "commit_step";
        @(negedge clk);
        bus.value = 14'd506;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (14) @(negedge clk);
        check("busy_in_commit", int'(bus.busy), 1);
        push(0, 7'h79);
        push(1, 7'h40);
        push(2, 7'h12);
        push(3, 7'h7F);
        step_now();
        repeat (3) step();
        check("busy_after_commit", int'(bus.busy), 0);
        frame(7'h02, 7'h40, 7'h12, 7'h7F);

        tname = "reset_mid";
        @(negedge clk);
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_mid_convert", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_busy", int'(bus.busy), 0);
        check("reset_mid_outputs", int'({anodes, segments}), 'h7FF);
        reset = 1'b0;
        last_exp = '{an: 4'hF, seg: 7'h7F};
        frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        tname = "v42"; load(14'd42, 0, '0); frame(7'h24, 7'h19, 7'h7F, 7'h7F);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
